// File: rtl/gps_sample_packer.sv
// Packs I/Q sample nibbles into bytes and queues them in a first-word-fall-through byte FIFO.
// Build macro GPS_PACKER_TESTPAT_EN adds a TEST_MODE input that packs a 4-bit counter instead.
module gps_sample_packer #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        MCU_CLK_25_000,
    input  logic                        RESET,
    input  logic                        GPS_I0,
    input  logic                        GPS_I1,
    input  logic                        GPS_Q0,
    input  logic                        GPS_Q1,
    input  logic                        DATAREADY,
    input  logic                        CLEAR_OVF,
`ifdef GPS_PACKER_TESTPAT_EN
    input  logic                        TEST_MODE,
`endif
    input  logic                        BYTE_READY,
    output logic [7:0]                  BYTE_OUT,
    output logic                        BYTE_VALID,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    output logic                        OVERFLOW
);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne    = (AW + 1)'(1);
    localparam logic [AW:0] LevelFull = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {EmptyHalf, HaveHigh} state_e;

    state_e      state_q, state_d;
    logic [3:0]  held_q, held_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  mem_q [FIFO_DEPTH];

    logic [3:0]  nibble;
    logic [7:0]  wr_byte;
    logic [AW:0] level;
    logic        wr_req, pop, full, accept, drop;

`ifdef GPS_PACKER_TESTPAT_EN
    logic [3:0] tcnt_q, tcnt_d;

    always_comb begin
        nibble = TEST_MODE ? tcnt_q : {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0};
        tcnt_d = DATAREADY ? tcnt_q + 4'd1 : tcnt_q;
    end
`else
    assign nibble = {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0};
`endif

    always_comb begin
        level   = wr_ptr_q - rd_ptr_q;
        full    = (level == LevelFull);
        pop     = (level != '0) && BYTE_READY;
        wr_req  = DATAREADY && (state_q == HaveHigh);
        wr_byte = {held_q, nibble};
        // A pop in the same cycle frees the slot the write lands in.
        accept  = wr_req && (!full || pop);
        drop    = wr_req && full && !pop;

        state_d = state_q;
        held_d  = held_q;
        if (DATAREADY) begin
            if (state_q == EmptyHalf) begin
                held_d  = nibble;
                state_d = HaveHigh;
            end else begin
                state_d = EmptyHalf;
            end
        end

        wr_ptr_d = accept ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + PtrOne : rd_ptr_q;

        if (drop) begin
            ovf_d = 1'b1;
        end else if (CLEAR_OVF) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge MCU_CLK_25_000) begin
        if (RESET) begin
            state_q  <= EmptyHalf;
            held_q   <= 4'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
`ifdef GPS_PACKER_TESTPAT_EN
            tcnt_q   <= 4'h0;
`endif
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
`ifdef GPS_PACKER_TESTPAT_EN
            tcnt_q   <= tcnt_d;
`endif
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge MCU_CLK_25_000) begin
        if (accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_byte;
        end
    end

    assign BYTE_OUT   = mem_q[rd_ptr_q[AW-1:0]];
    assign BYTE_VALID = (level != '0);
    assign FIFO_LEVEL = level;
    assign OVERFLOW   = ovf_q;

endmodule
